// File: rtl/rec_packer.sv
// Pairs 5-bit {bit, arr[3:0]} records into 10-bit words queued in an output FIFO; flush pads a lone record.
// Latency: a completing record or flush at edge N shows the word at out_word in cycle N+1 (no bypass).
// Backpressure: in_ready drops only while a record is held and the FIFO is full; optional REC_PACKER_MATCH_CNT_EN enables match_cnt.

module rec_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Guards keep the FIFO consistent even if a caller misbehaves.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Storage array; contents need no reset because the head is gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module rec_packer #(
    parameter int         DEPTH         = 4,
    parameter logic [3:0] MATCH_PATTERN = 4'b1001,
    parameter logic       PAD_BIT       = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic [3:0] in_arr,
    input  logic       flush,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [9:0] out_word,
    output logic       half_pending,
    output logic [7:0] match_cnt
);
    typedef enum logic {
        IDLE = 1'b0,
        HALF = 1'b1
    } state_t;

    state_t     state;
    logic       hold_bit;
    logic [3:0] hold_arr;

    logic       fifo_full;
    logic       fifo_empty;
    logic [9:0] fifo_head;
    logic       accept;
    logic       flush_push;
    logic       push;
    logic       pop;
    logic [9:0] push_word;

    // A held record can only be completed when there is room for the word, so
    // in_ready depends on state and FIFO fill only, never on out_ready.
    assign in_ready     = (state == IDLE) || !fifo_full;
    assign accept       = in_valid && in_ready;
    // A real record always beats a pad when both arrive in the same cycle.
    assign flush_push   = (state == HALF) && flush && !accept && !fifo_full;
    assign push         = ((state == HALF) && accept) || flush_push;
    assign push_word    = accept ? {hold_bit, hold_arr, in_bit, in_arr}
                                 : {hold_bit, hold_arr, PAD_BIT, 4'b0000};
    assign out_valid    = !fifo_empty;
    assign pop          = out_valid && out_ready;
    assign out_word     = out_valid ? fifo_head : 10'd0;
    assign half_pending = (state == HALF);

    rec_fifo #(
        .DEPTH (DEPTH),
        .W     (10)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (push_word),
        .pop      (pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Pairing FSM: IDLE captures the first record, HALF completes it by a record or a flush pad.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_bit <= 1'b0;
            hold_arr <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        hold_bit <= in_bit;
                        hold_arr <= in_arr;
                        state    <= HALF;
                    end
                end
                HALF: begin
                    if (accept || flush_push) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef REC_PACKER_MATCH_CNT_EN
    logic [7:0] match_q;

    // Saturating count of accepted records matching the pattern; pads never pass through accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            match_q <= 8'h00;
        end else if (accept && (in_arr == MATCH_PATTERN) && (match_q != 8'hFF)) begin
            match_q <= match_q + 8'h01;
        end
    end

    assign match_cnt = match_q;
`else
    logic unused_match_cfg;

    assign unused_match_cfg = ^MATCH_PATTERN;
    assign match_cnt        = 8'h00;
`endif
endmodule

// File: tb/tb_rec_packer.sv
// Directed bench for rec_packer: reset, pairing, flush, flush/record race, backpressure,
// mid-stream reset and match counter saturation, with hand-computed expectations.
// Inputs change #1 after the rising edge; outputs are checked in that same settled window.

module tb_rec_packer;
`ifdef REC_PACKER_MATCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       in_bit;
    logic [3:0] in_arr;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_word;
    logic       half_pending;
    logic [7:0] match_cnt;

    int checks = 0;
    int errors = 0;

    rec_packer #(
        .DEPTH         (4),
        .MATCH_PATTERN (4'b1001),
        .PAD_BIT       (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_bit       (in_bit),
        .in_arr       (in_arr),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_word     (out_word),
        .half_pending (half_pending),
        .match_cnt    (match_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
        checks++; if (out_word !== 10'd0) begin errors++; $display("FAIL reset_out_word got %b expected 0", out_word); end
        checks++; if (half_pending !== 1'b0) begin errors++; $display("FAIL reset_half_pending got %b expected 0", half_pending); end
        checks++; if (match_cnt !== 8'h00) begin errors++; $display("FAIL reset_match_cnt got %h expected 00", match_cnt); end
    endtask

    task automatic test_pair();
        out_ready = 1'b1;
        in_valid = 1'b1; in_bit = 1'b1; in_arr = 4'b1001;
        step();
        checks++; if (half_pending !== 1'b1) begin errors++; $display("FAIL pair_half got %b expected 1", half_pending); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pair_no_early_word got %b expected 0", out_valid); end
        in_bit = 1'b0; in_arr = 4'b0110;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pair_valid got %b expected 1", out_valid); end
        checks++; if (out_word !== 10'b1100100110) begin errors++; $display("FAIL pair_word got %b expected 1100100110", out_word); end
        checks++; if (half_pending !== 1'b0) begin errors++; $display("FAIL pair_idle got %b expected 0", half_pending); end
        checks++; if (match_cnt !== (CNT_EN ? 8'd1 : 8'd0)) begin errors++; $display("FAIL pair_match_cnt got %h expected %h", match_cnt, CNT_EN ? 8'd1 : 8'd0); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pair_single_cycle got %b expected 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        in_valid = 1'b1; in_bit = 1'b0; in_arr = 4'b0011;
        step();
        in_valid = 1'b0;
        checks++; if (half_pending !== 1'b1) begin errors++; $display("FAIL flush_held got %b expected 1", half_pending); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (half_pending !== 1'b0) begin errors++; $display("FAIL flush_half_fall got %b expected 0", half_pending); end
        checks++; if (out_word !== 10'b0001110000) begin errors++; $display("FAIL flush_word got %b expected 0001110000", out_word); end
        checks++; if (match_cnt !== (CNT_EN ? 8'd1 : 8'd0)) begin errors++; $display("FAIL flush_pad_not_counted got %h expected %h", match_cnt, CNT_EN ? 8'd1 : 8'd0); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drained got %b expected 0", out_valid); end
        // Flush while IDLE must do nothing.
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_flush_word got %b expected 0", out_valid); end
        checks++; if (half_pending !== 1'b0) begin errors++; $display("FAIL idle_flush_state got %b expected 0", half_pending); end
    endtask

    task automatic test_flush_race();
        out_ready = 1'b1;
        in_valid = 1'b1; in_bit = 1'b1; in_arr = 4'b1111;
        step();
        in_bit = 1'b0; in_arr = 4'b0101; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        checks++; if (out_word !== 10'b1111100101) begin errors++; $display("FAIL race_word got %b expected 1111100101", out_word); end
        checks++; if (half_pending !== 1'b0) begin errors++; $display("FAIL race_idle got %b expected 0", half_pending); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL race_no_second_word got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [3:0] v;
        logic [3:0] a;
        logic [3:0] b;
        logic [9:0] exp_w;
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            v = 4'(i);
            in_valid = 1'b1; in_bit = v[0]; in_arr = v;
            if (i == 8) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_full_ready got %b expected 1", in_ready); end
            end
            step();
        end
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_half_full_ready got %b expected 0", in_ready); end
        checks++; if (half_pending !== 1'b1) begin errors++; $display("FAIL bp_half got %b expected 1", half_pending); end
        checks++; if (out_word !== 10'b0000010001) begin errors++; $display("FAIL bp_head got %b expected 0000010001", out_word); end
        // Flush against a full FIFO is held off.
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (half_pending !== 1'b1) begin errors++; $display("FAIL bp_flush_blocked got %b expected 1", half_pending); end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a = 4'(2 * k);
            b = 4'(2 * k + 1);
            exp_w = {a[0], a, b[0], b};
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_%0d got %b expected 1", k, out_valid); end
            checks++; if (out_word !== exp_w) begin errors++; $display("FAIL bp_word_%0d got %b expected %b", k, out_word, exp_w); end
            step();
            if (k == 0) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_return got %b expected 1", in_ready); end
            end
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b expected 0", out_valid); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (out_word !== 10'b0100010000) begin errors++; $display("FAIL bp_pad_word got %b expected 0100010000", out_word); end
        checks++; if (half_pending !== 1'b0) begin errors++; $display("FAIL bp_pad_idle got %b expected 0", half_pending); end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_bit = 1'b1; in_arr = 4'b1001;
            step();
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || half_pending !== 1'b1) begin errors++; $display("FAIL rmid_setup got valid %b half %b expected 1 1", out_valid, half_pending); end
        checks++; if (match_cnt !== (CNT_EN ? 8'd6 : 8'd0)) begin errors++; $display("FAIL rmid_cnt_before got %h expected %h", match_cnt, CNT_EN ? 8'd6 : 8'd0); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got %b expected 0", out_valid); end
        checks++; if (out_word !== 10'd0) begin errors++; $display("FAIL rmid_out_word got %b expected 0", out_word); end
        checks++; if (half_pending !== 1'b0) begin errors++; $display("FAIL rmid_half got %b expected 0", half_pending); end
        checks++; if (match_cnt !== 8'h00) begin errors++; $display("FAIL rmid_match_cnt got %h expected 00", match_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b expected 1", in_ready); end
        out_ready = 1'b1;
        in_valid = 1'b1; in_bit = 1'b1; in_arr = 4'b0001;
        step();
        in_bit = 1'b0; in_arr = 4'b0010;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_clean_valid got %b expected 1", out_valid); end
        checks++; if (out_word !== 10'b1000100010) begin errors++; $display("FAIL rmid_clean_word got %b expected 1000100010", out_word); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_clean_single got %b expected 0", out_valid); end
    endtask

    task automatic test_saturate();
        out_ready = 1'b1;
        in_bit = 1'b0; in_arr = 4'b1001;
        for (int i = 0; i < 254; i++) begin
            in_valid = 1'b1;
            step();
        end
        checks++; if (match_cnt !== (CNT_EN ? 8'hFE : 8'h00)) begin errors++; $display("FAIL sat_254 got %h expected %h", match_cnt, CNT_EN ? 8'hFE : 8'h00); end
        for (int i = 0; i < 46; i++) begin
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        checks++; if (match_cnt !== (CNT_EN ? 8'hFF : 8'h00)) begin errors++; $display("FAIL sat_300 got %h expected %h", match_cnt, CNT_EN ? 8'hFF : 8'h00); end
        checks++; if (half_pending !== 1'b0) begin errors++; $display("FAIL sat_even_idle got %b expected 0", half_pending); end
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sat_drained got %b expected 0", out_valid); end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        in_arr    = 4'b0000;
        flush     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_pair();
        test_flush();
        test_flush_race();
        test_backpressure();
        test_reset_mid();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rec_packer.md
REC_PACKER -- requirements
Module: rec_packer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set output FIFO depth in 10-bit words (power of two, 2..16).
REQ-002 Parameter MATCH_PATTERN, default 4'b1001, SHALL set the 4-bit array value counted by the match counter.
REQ-003 Parameter PAD_BIT, default 1'b1, SHALL set the bit field of the pad record inserted on flush.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit, SHALL be the synchronous active-low reset.
REQ-006 Ports in_valid (input, 1), in_ready (output, 1), in_bit (input, 1) and in_arr (input, 4) SHALL form the record input; one record is accepted when in_valid && in_ready.
REQ-007 Port flush, input, 1 bit, SHALL request completion of a half-filled pair.
REQ-008 Ports out_valid (output, 1), out_ready (input, 1) and out_word (output, 10) SHALL form the word output; one word is popped when out_valid && out_ready.
REQ-009 Port half_pending, output, 1 bit, SHALL be high while one record is held awaiting its partner.
REQ-010 Port match_cnt, output, 8 bits, SHALL carry the saturating match count (see REQ-024).

Function
REQ-011 The FSM SHALL have exactly two states: IDLE (no held record) and HALF (one held record); half_pending = (state == HALF).
REQ-012 IDLE, record accepted -> store {in_bit, in_arr} in the hold register; go to HALF; no FIFO push.
REQ-013 HALF, record accepted -> push {held_bit, held_arr, in_bit, in_arr} (first record in [9:5]); go to IDLE.
REQ-014 in_ready SHALL be 1 in IDLE and !fifo_full in HALF; it SHALL NOT depend combinationally on out_ready.
REQ-015 HALF, flush high, no record accepted this cycle, FIFO not full -> push {held_bit, held_arr, PAD_BIT, 4'b0000}; go to IDLE.
REQ-016 HALF with FIFO full and flush high -> no action; the flush takes effect on the first cycle with the FIFO not full, provided flush is still high.
REQ-017 A record accept and flush in the same cycle -> record wins (normal pairing); flush ignored that cycle.
REQ-018 Flush in IDLE SHALL have no effect.
REQ-019 out_valid SHALL equal (fifo_count != 0); out_word SHALL be the FIFO head when out_valid = 1, else 10'd0.
REQ-020 Latency: a push at edge N SHALL make the word visible at out_word after edge N (out_valid = 1 in cycle N+1) when the FIFO was empty; no same-cycle bypass.
REQ-021 Simultaneous push and pop SHALL leave fifo_count unchanged and preserve order; pointers SHALL wrap modulo DEPTH.
REQ-022 A pop with out_valid = 0 SHALL be ignored; a push SHALL never occur when full.

Reset
REQ-023 With rst_n = 0 at a rising edge: state = IDLE, FIFO emptied, hold register = 0, match_cnt = 0; thus in_ready = 1, out_valid = 0, out_word = 0 and half_pending = 0 in the following cycle. Reset in HALF or with a non-empty FIFO SHALL discard all held data, and no partial word SHALL be emitted.

Configuration
REQ-024 With macro REC_PACKER_MATCH_CNT_EN defined, match_cnt SHALL increment by 1 for each accepted record whose in_arr == MATCH_PATTERN, saturating at 8'hFF; pad records SHALL NOT count.
REQ-025 Without REC_PACKER_MATCH_CNT_EN, the counter logic SHALL be absent and match_cnt SHALL be tied to 8'h00; the port list SHALL be unchanged.

Verification
REQ-026 Scenario: after reset, send {1,4'b1001} then {0,4'b0110} with out_ready = 1 -> out_word = 10'b1_1001_0_0110 with out_valid high for exactly 1 cycle, and match_cnt = 1 (macro defined).
REQ-027 Scenario: send {0,4'b0011}, then pulse flush for 1 cycle -> out_word = 10'b0_0011_1_0000; half_pending falls on the flush edge.
REQ-028 Scenario: hold out_ready = 0 with DEPTH = 4 and send 9 records -> 4 words stored; in_ready = 0 in HALF after the 9th record; then release out_ready -> the 4 words come out in order and in_ready returns to 1.
REQ-029 Scenario: in HALF, in_valid = 1 and flush = 1 in the same cycle -> word contains the new record, not the pad; no second word is produced.
REQ-030 Scenario: assert rst_n = 0 for 1 cycle while in HALF with 2 words queued -> out_valid = 0, half_pending = 0, match_cnt = 0 next cycle; the next two records form a clean first word.
REQ-031 Scenario: send 300 records of in_arr = 4'b1001 -> match_cnt = 8'hFF with the macro defined, and 8'h00 without it.
